// File: rtl/srm_ctrl_pkg.sv
// Shared encodings for the Simple RISC Machine controller: state codes, opcode/op fields,
// register-select and write-back-source values, plus the DECODE dispatch rule.
package srm_ctrl_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_WAIT      = 3'd0;
    localparam logic [STATE_W-1:0] ST_DECODE    = 3'd1;
    localparam logic [STATE_W-1:0] ST_GET_A     = 3'd2;
    localparam logic [STATE_W-1:0] ST_GET_B     = 3'd3;
    localparam logic [STATE_W-1:0] ST_ALU       = 3'd4;
    localparam logic [STATE_W-1:0] ST_WRITE_IMM = 3'd5;
    localparam logic [STATE_W-1:0] ST_WRITE_REG = 3'd6;
    localparam logic [STATE_W-1:0] ST_CMP       = 3'd7;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_ADD    = 2'b00;
    localparam logic [1:0] OP_CMP    = 2'b01;
    localparam logic [1:0] OP_AND    = 2'b10;
    localparam logic [1:0] OP_MVN    = 2'b11;
    localparam logic [1:0] OP_MOVIMM = 2'b10;
    localparam logic [1:0] OP_MOVREG = 2'b00;

    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_RN   = 3'b001;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RM   = 3'b100;

    localparam logic [1:0] VSEL_C   = 2'b00;
    localparam logic [1:0] VSEL_IMM = 2'b10;

    // State that follows DECODE for a latched instruction; unknown encodings return to WAIT.
    function automatic logic [STATE_W-1:0] decode_next(input logic [2:0] opc, input logic [1:0] op);
        logic [STATE_W-1:0] nxt;
        nxt = ST_WAIT;
        if (opc == OPC_MOV && op == OP_MOVIMM) begin
            nxt = ST_WRITE_IMM;
        end else if (opc == OPC_MOV && op == OP_MOVREG) begin
            nxt = ST_GET_B;
        end else if (opc == OPC_ALU) begin
            nxt = (op == OP_MVN) ? ST_GET_B : ST_GET_A;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/srm_vdff.sv
// Width-parameterised D flip-flop with load enable and synchronous active-high reset.
module srm_vdff #(
    parameter int unsigned   N      = 1,
    parameter logic [N-1:0]  RstVal = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] q_o
);

    logic [N-1:0] q_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q <= RstVal;
        end else if (load_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/srm_fsm_ctrl.sv
// Moore controller sequencing the SRM datapath one instruction at a time; w flags readiness.
module srm_fsm_ctrl
    import srm_ctrl_pkg::*;
#(
    parameter int unsigned SW = STATE_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic       w,
    output logic [2:0] nsel,
    output logic [1:0] vsel,
    output logic       loada,
    output logic       loadb,
    output logic       asel,
    output logic       bsel,
    output logic       loadc,
    output logic       loads,
    output logic       write
);

    logic [SW-1:0] state_q, state_d;
    logic [4:0]    ir_q;
    logic [2:0]    ir_opc;
    logic [1:0]    ir_op;
    logic          start;

    assign start  = (state_q == ST_WAIT) && s;
    assign ir_opc = ir_q[4:2];
    assign ir_op  = ir_q[1:0];

    srm_vdff #(
        .N      (SW),
        .RstVal (ST_WAIT)
    ) u_state (
        .clk_i  (clk),
        .rst_i  (reset),
        .load_i (1'b1),
        .d_i    (state_d),
        .q_o    (state_q)
    );

    // Decode works only from this copy, so the IR may change mid-instruction.
    srm_vdff #(
        .N      (5),
        .RstVal (5'b0)
    ) u_ir (
        .clk_i  (clk),
        .rst_i  (reset),
        .load_i (start),
        .d_i    ({opcode, op}),
        .q_o    (ir_q)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_WAIT:   state_d = s ? ST_DECODE : ST_WAIT;
            ST_DECODE: state_d = decode_next(ir_opc, ir_op);
            ST_GET_A:  state_d = ST_GET_B;
            ST_GET_B:  state_d = (ir_opc == OPC_ALU && ir_op == OP_CMP) ? ST_CMP : ST_ALU;
            ST_ALU:    state_d = ST_WRITE_REG;
            default:   state_d = ST_WAIT;
        endcase
    end

    always_comb begin
        w     = 1'b0;
        nsel  = NSEL_NONE;
        vsel  = VSEL_C;
        loada = 1'b0;
        loadb = 1'b0;
        asel  = 1'b0;
        bsel  = 1'b0;
        loadc = 1'b0;
        loads = 1'b0;
        write = 1'b0;
        unique case (state_q)
            ST_WAIT: w = 1'b1;
            ST_GET_A: begin
                nsel  = NSEL_RN;
                loada = 1'b1;
            end
            ST_GET_B: begin
                nsel  = NSEL_RM;
                loadb = 1'b1;
            end
            ST_ALU: begin
                loadc = 1'b1;
                // MOV-reg and MVN pass only B through, so zero the A operand.
                asel  = (ir_opc == OPC_MOV) || (ir_op == OP_MVN);
            end
            ST_CMP: loads = 1'b1;
            ST_WRITE_REG: begin
                nsel  = NSEL_RD;
                vsel  = VSEL_C;
                write = 1'b1;
            end
            ST_WRITE_IMM: begin
                nsel  = NSEL_RN;
                vsel  = VSEL_IMM;
                write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_srm_fsm_ctrl.sv
// Bench for srm_fsm_ctrl: directed and random instruction streams checked cycle by cycle
// against a queue of expected output vectors built from the instruction class.
module tb_srm_fsm_ctrl;

    logic       clk = 1'b0;
    logic       reset, s;
    logic [2:0] opcode;
    logic [1:0] op;
    logic       w, loada, loadb, asel, bsel, loadc, loads, write;
    logic [2:0] nsel;
    logic [1:0] vsel;

    int checks = 0;
    int errors = 0;

    srm_fsm_ctrl dut (
        .clk    (clk),
        .reset  (reset),
        .s      (s),
        .opcode (opcode),
        .op     (op),
        .w      (w),
        .nsel   (nsel),
        .vsel   (vsel),
        .loada  (loada),
        .loadb  (loadb),
        .asel   (asel),
        .bsel   (bsel),
        .loadc  (loadc),
        .loads  (loads),
        .write  (write)
    );

    always #5 clk = ~clk;

    // Vector layout: {w, nsel[2:0], vsel[1:0], loada, loadb, asel, bsel, loadc, loads, write}
    function automatic logic [12:0] mk(input logic ww, input logic [2:0] ns, input logic [1:0] vs,
                                       input logic la, input logic lb, input logic as_,
                                       input logic lc, input logic ls, input logic wr);
        return {ww, ns, vs, la, lb, as_, 1'b0, lc, ls, wr};
    endfunction

    logic [12:0] v_idle, v_dec, v_geta, v_getb, v_alu0, v_alu1, v_cmp, v_wreg, v_wimm;
    logic [12:0] exp_q[$];
    logic [12:0] exp_cur;
    logic        exp_idle;

    // Expected cycle-by-cycle outputs after the start edge, up to (not including) the return to WAIT.
    task automatic build_seq(input logic [2:0] opc, input logic [1:0] o);
        exp_q.delete();
        exp_q.push_back(v_dec);
        if (opc == 3'b110 && o == 2'b10) begin
            exp_q.push_back(v_wimm);
        end else if ((opc == 3'b110 && o == 2'b00) || (opc == 3'b101 && o == 2'b11)) begin
            exp_q.push_back(v_getb);
            exp_q.push_back(v_alu1);
            exp_q.push_back(v_wreg);
        end else if (opc == 3'b101 && (o == 2'b00 || o == 2'b10)) begin
            exp_q.push_back(v_geta);
            exp_q.push_back(v_getb);
            exp_q.push_back(v_alu0);
            exp_q.push_back(v_wreg);
        end else if (opc == 3'b101 && o == 2'b01) begin
            exp_q.push_back(v_geta);
            exp_q.push_back(v_getb);
            exp_q.push_back(v_cmp);
        end
    endtask

    task automatic step(input logic rst, input logic st, input logic [2:0] opc, input logic [1:0] o);
        logic [12:0] act;
        reset  = rst;
        s      = st;
        opcode = opc;
        op     = o;
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            exp_cur  = v_idle;
            exp_idle = 1'b1;
        end else if (exp_idle && st) begin
            build_seq(opc, o);
            exp_cur  = exp_q.pop_front();
            exp_idle = 1'b0;
        end else if (exp_q.size() != 0) begin
            exp_cur = exp_q.pop_front();
        end else begin
            exp_cur  = v_idle;
            exp_idle = 1'b1;
        end
        #1;
        act = {w, nsel, vsel, loada, loadb, asel, bsel, loadc, loads, write};
        checks++;
        assert (act === exp_cur) else begin
            errors++;
            $error("FAIL outputs t=%0t instr=%b/%b observed=%b expected=%b",
                   $time, opcode, op, act, exp_cur);
        end
    endtask

    task automatic run_instr(input logic [2:0] opc, input logic [1:0] o, input int cycles);
        step(1'b0, 1'b1, opc, o);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, opc, o);
    endtask

    initial begin
        v_idle = mk(1, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0);
        v_dec  = mk(0, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0);
        v_geta = mk(0, 3'b001, 2'b00, 1, 0, 0, 0, 0, 0);
        v_getb = mk(0, 3'b100, 2'b00, 0, 1, 0, 0, 0, 0);
        v_alu0 = mk(0, 3'b000, 2'b00, 0, 0, 0, 1, 0, 0);
        v_alu1 = mk(0, 3'b000, 2'b00, 0, 0, 1, 1, 0, 0);
        v_cmp  = mk(0, 3'b000, 2'b00, 0, 0, 0, 0, 1, 0);
        v_wreg = mk(0, 3'b010, 2'b00, 0, 0, 0, 0, 0, 1);
        v_wimm = mk(0, 3'b001, 2'b10, 0, 0, 0, 0, 0, 1);
        exp_cur  = v_idle;
        exp_idle = 1'b1;

        step(1'b1, 1'b0, 3'b000, 2'b00);
        step(1'b1, 1'b0, 3'b000, 2'b00);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'b000, 2'b00);

        run_instr(3'b110, 2'b10, 3);               // MOV imm
        // ADD with the IR scribbled on while the instruction is in flight
        step(1'b0, 1'b1, 3'b101, 2'b00);
        step(1'b0, 1'b0, 3'b000, 2'b00);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 3'b000, 2'b00);
        run_instr(3'b101, 2'b10, 6);               // AND
        run_instr(3'b101, 2'b01, 5);               // CMP
        run_instr(3'b110, 2'b00, 5);               // MOV reg
        run_instr(3'b101, 2'b11, 5);               // MVN
        // Reset in the ALU state of an ADD
        step(1'b0, 1'b1, 3'b101, 2'b00);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'b101, 2'b00);
        step(1'b1, 1'b1, 3'b101, 2'b00);
        step(1'b0, 1'b0, 3'b101, 2'b00);
        step(1'b0, 1'b0, 3'b101, 2'b00);
        run_instr(3'b111, 2'b00, 3);               // illegal
        // s held high: back-to-back instructions
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 3'b101, 2'b01);

        for (int i = 0; i < 2000; i++) begin
            logic       r, st;
            logic [2:0] opc;
            logic [1:0] o;
            r   = ($urandom_range(0, 59) == 0);
            st  = ($urandom_range(0, 2) != 0);
            opc = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                : (($urandom_range(0, 1) == 0) ? 3'b101 : 3'b110);
            o   = 2'($urandom_range(0, 3));
            step(r, st, opc, o);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
